// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants and register bundle for the seven-segment scan controller.
package seg7_scan_ctrl_pkg;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [7:0] AN_OFF     = 8'hFF;
    localparam int unsigned NUM_DIGITS = 8;

    // One complete display image: hex nibbles, decimal points, digit enables.
    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  den;
    } disp_regs_t;

    localparam disp_regs_t DISP_RESET = '{data: '0, dp: '0, den: '1};

endpackage

// File: rtl/seg7_scan_ctrl_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module hex_to_seg7
    import seg7_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment driver with frame-synchronous commit.
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int unsigned DIGIT_DIV = 50000,
    parameter int unsigned BLANK_CYC = 250,
    parameter bit          BLANK_LZ  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic [7:0]  wr_dp,
    input  logic [7:0]  wr_den,
    output logic        upd_pending,
    output logic        frame_tick,
    output logic [7:0]  anode,
    output logic [6:0]  cathode,
    output logic        dp
);

    localparam int unsigned CNT_W = (DIGIT_DIV > 1) ? $clog2(DIGIT_DIV) : 1;

    logic [CNT_W-1:0] div_cnt;
    logic [2:0]       digit_idx;
    logic             slot_end;
    disp_regs_t       shadow;
    disp_regs_t       display;
    disp_regs_t       incoming;
    logic [7:0]       lz_blank;
    logic             upper_nz;
    logic [3:0]       cur_nibble;
    logic [6:0]       cur_seg;
    logic             digit_on;

    assign slot_end   = (div_cnt == CNT_W'(DIGIT_DIV - 1));
    assign frame_tick = slot_end && (digit_idx == 3'd7);
    assign incoming   = '{data: wr_data, dp: wr_dp, den: wr_den};

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            digit_idx <= '0;
        end else if (slot_end) begin
            div_cnt   <= '0;
            digit_idx <= digit_idx + 3'd1;
        end else begin
            div_cnt   <= div_cnt + CNT_W'(1);
        end
    end

    // A write landing on the boundary cycle bypasses the shadow so it is never left pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow      <= DISP_RESET;
            display     <= DISP_RESET;
            upd_pending <= 1'b0;
        end else begin
            if (wr_en)
                shadow <= incoming;
            if (frame_tick) begin
                display     <= wr_en ? incoming : shadow;
                upd_pending <= 1'b0;
            end else if (wr_en) begin
                upd_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        lz_blank = '0;
        upper_nz = 1'b0;
        for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_nz    = upper_nz | (display.data[4*i +: 4] != 4'h0);
            lz_blank[i] = BLANK_LZ && !upper_nz;
        end
    end

    assign cur_nibble = display.data[{digit_idx, 2'b00} +: 4];
    assign digit_on   = display.den[digit_idx] && !lz_blank[digit_idx];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            anode   <= AN_OFF;
            cathode <= SEG_BLANK;
            dp      <= 1'b1;
        end else if ((div_cnt < CNT_W'(BLANK_CYC)) || !digit_on) begin
            anode   <= AN_OFF;
            cathode <= SEG_BLANK;
            dp      <= 1'b1;
        end else begin
            anode   <= ~(8'b1 << digit_idx);
            cathode <= cur_seg;
            dp      <= ~display.dp[digit_idx];
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIGIT_DIV=8, BLANK_CYC=2 (64-cycle frames).
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic [7:0]  wr_dp = '0;
    logic [7:0]  wr_den = '1;

    logic       upd_pending, frame_tick, dp;
    logic [7:0] anode;
    logic [6:0] cathode;
    logic       upd_pending_lz, frame_tick_lz, dp_lz;
    logic [7:0] anode_lz;
    logic [6:0] cathode_lz;

    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    seg7_scan_ctrl #(.DIGIT_DIV(8), .BLANK_CYC(2), .BLANK_LZ(1'b0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_dp(wr_dp),
        .wr_den(wr_den), .upd_pending(upd_pending), .frame_tick(frame_tick),
        .anode(anode), .cathode(cathode), .dp(dp)
    );

    seg7_scan_ctrl #(.DIGIT_DIV(8), .BLANK_CYC(2), .BLANK_LZ(1'b1)) dut_lz (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_dp(wr_dp),
        .wr_den(wr_den), .upd_pending(upd_pending_lz), .frame_tick(frame_tick_lz),
        .anode(anode_lz), .cathode(cathode_lz), .dp(dp_lz)
    );

    always @(negedge clk) begin
        checks++;
        if (!$onehot0(~anode) || !$onehot0(~anode_lz)) begin
            errors++;
            $display("FAIL onehot t=%0t anode=%h anode_lz=%h required ~anode one-hot or zero",
                     $time, anode, anode_lz);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one 64-cycle frame from a frame start, checking the scan of the given image.
    task automatic check_frame(input string name, input bit sel, input logic [7:0] lit,
                               input logic [7:0][6:0] cat, input logic [7:0] dpl,
                               input int wr_at, input logic [31:0] wd,
                               input logic [7:0] wdp, input logic [7:0] wden);
        bit          pend = 1'b0;
        bit          bnd, wrote;
        int unsigned p, d, i;
        logic [7:0]  ea, oa;
        logic [6:0]  ec, oc;
        logic        ed, od, ot, op;
        for (int j = 0; j < 64; j++) begin
            bnd   = (cyc % 64 == 63);
            wrote = (j == wr_at);
            if (wrote) begin
                wr_en = 1'b1; wr_data = wd; wr_dp = wdp; wr_den = wden;
            end
            tick();
            wr_en = 1'b0;
            if (bnd) pend = 1'b0;
            else if (wrote) pend = 1'b1;
            p  = cyc - 1;
            d  = p % 8;
            i  = (p / 8) % 8;
            oa = sel ? anode_lz : anode;
            oc = sel ? cathode_lz : cathode;
            od = sel ? dp_lz : dp;
            ot = sel ? frame_tick_lz : frame_tick;
            op = sel ? upd_pending_lz : upd_pending;
            if (d < 2 || !lit[i]) begin
                ea = 8'hFF; ec = 7'h7F; ed = 1'b1;
            end else begin
                ea = ~(8'b1 << i); ec = cat[i]; ed = ~dpl[i];
            end
            checks += 4;
            if (oa !== ea) begin
                errors++;
                $display("FAIL %s_anode cyc=%0d got=%h exp=%h", name, cyc, oa, ea);
            end
            if ((d < 2 || lit[i]) && oc !== ec) begin
                errors++;
                $display("FAIL %s_cathode cyc=%0d got=%h exp=%h", name, cyc, oc, ec);
            end
            if (od !== ed) begin
                errors++;
                $display("FAIL %s_dp cyc=%0d got=%b exp=%b", name, cyc, od, ed);
            end
            if (ot !== (cyc % 64 == 63)) begin
                errors++;
                $display("FAIL %s_frame_tick cyc=%0d got=%b exp=%b", name, cyc, ot, (cyc % 64 == 63));
            end
            if (op !== pend) begin
                errors++;
                $display("FAIL %s_upd_pending cyc=%0d got=%b exp=%b", name, cyc, op, pend);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks += 5;
        if (anode !== 8'hFF)    begin errors++; $display("FAIL reset_anode got=%h exp=FF", anode); end
        if (cathode !== 7'h7F)  begin errors++; $display("FAIL reset_cathode got=%h exp=7F", cathode); end
        if (dp !== 1'b1)        begin errors++; $display("FAIL reset_dp got=%b exp=1", dp); end
        if (upd_pending !== 1'b0) begin errors++; $display("FAIL reset_upd_pending got=%b exp=0", upd_pending); end
        if (frame_tick !== 1'b0)  begin errors++; $display("FAIL reset_frame_tick got=%b exp=0", frame_tick); end
        rst = 1'b0;
    endtask

    task automatic test_scan_default();
        check_frame("scan0", 1'b0, 8'hFF, {8{7'h40}}, 8'h00, -1, '0, '0, '1);
    endtask

    task automatic test_mid_frame_write();
        check_frame("old", 1'b0, 8'hFF, {8{7'h40}}, 8'h00, 20, 32'h89ABCDEF, 8'h00, 8'hFF);
        check_frame("new", 1'b0, 8'hFF,
                    {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E},
                    8'h00, -1, '0, '0, '1);
    endtask

    task automatic test_boundary_write();
        check_frame("bnd", 1'b0, 8'hFF,
                    {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E},
                    8'h00, 63, 32'h00000001, 8'h00, 8'hFF);
        check_frame("bnd_new", 1'b0, 8'hFF, {{7{7'h40}}, 7'h79}, 8'h00, -1, '0, '0, '1);
    endtask

    task automatic test_blank_lz();
        check_frame("lz1", 1'b1, 8'h01, {{7{7'h40}}, 7'h79}, 8'h00,
                    10, 32'h00000305, 8'h00, 8'hFF);
        check_frame("lz305", 1'b1, 8'h07, {{5{7'h40}}, 7'h30, 7'h40, 7'h12}, 8'h00,
                    10, 32'h00000000, 8'h00, 8'hFF);
        check_frame("lz0", 1'b1, 8'h01, {8{7'h40}}, 8'h00,
                    5, 32'h76543210, 8'h01, 8'h0F);
    endtask

    task automatic test_den_dp();
        check_frame("den", 1'b0, 8'h0F,
                    {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40},
                    8'h01, -1, '0, '0, '1);
    endtask

    task automatic test_reset_mid_slot();
        for (int j = 0; j < 43; j++) begin
            if (j == 3) begin
                wr_en = 1'b1; wr_data = 32'h12345678; wr_dp = 8'hFF; wr_den = 8'hFF;
            end
            tick();
            wr_en = 1'b0;
            if (j == 3) begin
                checks++;
                if (upd_pending !== 1'b1) begin
                    errors++;
                    $display("FAIL pend_before_rst got=%b exp=1", upd_pending);
                end
            end
        end
        rst = 1'b1;
        tick();
        checks += 5;
        if (anode !== 8'hFF)      begin errors++; $display("FAIL midrst_anode got=%h exp=FF", anode); end
        if (cathode !== 7'h7F)    begin errors++; $display("FAIL midrst_cathode got=%h exp=7F", cathode); end
        if (dp !== 1'b1)          begin errors++; $display("FAIL midrst_dp got=%b exp=1", dp); end
        if (upd_pending !== 1'b0) begin errors++; $display("FAIL midrst_upd_pending got=%b exp=0", upd_pending); end
        if (frame_tick !== 1'b0)  begin errors++; $display("FAIL midrst_frame_tick got=%b exp=0", frame_tick); end
        rst = 1'b0;
        check_frame("post_rst0", 1'b0, 8'hFF, {8{7'h40}}, 8'h00, -1, '0, '0, '1);
        check_frame("post_rst1", 1'b0, 8'hFF, {8{7'h40}}, 8'h00, -1, '0, '0, '1);
    endtask

    initial begin
        test_reset();
        test_scan_default();
        test_mid_frame_write();
        test_boundary_write();
        test_blank_lz();
        test_den_dp();
        test_reset_mid_slot();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
